rect_scheduler: RTL and testbench
=================================

# rect_scheduler

Frame-synchronous rectangle layer controller for the pixel datapath. It sits between the display signal generator (sx, sy, de) and the colour output registers. It holds NRECT rectangle descriptors in a shadow bank, which a configuration client writes through a valid/ready port. A commit request copies the shadow bank into the active bank, and the copy happens only at a frame boundary, so a frame never shows a half-updated scene. Every pixel clock it resolves which enabled active rectangle covers (sx, sy), with fixed priority, and emits the registered 12-bit colour.

## Interface
- COORDWID, 10, width of sx/sy and of all rectangle coordinates
- NRECT, 4, number of rectangle descriptors (2..8)
- BG_COLOR, 12'h142, background {r,g,b} 4 bits each, used when de=1 and no rectangle hits

- pix_clk  in  1  pixel clock; the only clock
- rst_pix_n  in  1  asynchronous, active-low reset
- sx, sy  in  COORDWID  current pixel coordinates from the display signal generator
- de  in  1  data enable for (sx, sy)
- frame_tick  in  1  single-cycle pulse, one per frame, at the first non-active pixel after the last active line
- cfg_valid  in  1  descriptor write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_idx  in  $clog2(NRECT)  descriptor index
- cfg_en  in  1  descriptor enable
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  COORDWID each  bounds, inclusive start, exclusive end
- cfg_color  in  12  {r,g,b}
- cfg_commit  in  1  request shadow-to-active copy at the next frame_tick
- commit_done  out  1  single-cycle pulse in the cycle after the copy
- pix_de  out  1  de delayed by 2 cycles
- pix_color  out  12  resolved colour, aligned with pix_de
- pix_hit  out  1  some rectangle covered the pixel, aligned with pix_de
- pix_idx  out  $clog2(NRECT)  index of the winning rectangle; 0 when pix_hit=0

## Operation
- Configuration FSM has two states, OPEN and PEND. Reset state is OPEN.
- cfg_ready = (state==OPEN), combinational from the state register.
- OPEN:
  - An accepted write updates shadow[cfg_idx] at the clock edge.
  - If cfg_commit=1, the FSM goes to PEND. A write accepted in the same cycle is included in that commit.
- PEND:
  - Writes are refused and cfg_commit is ignored.
  - On frame_tick, all NRECT descriptors are copied shadow→active in one cycle. The FSM then returns to OPEN and commit_done pulses on the next cycle.
- A frame_tick in the same cycle that a commit is accepted in OPEN does not perform the copy. The copy waits for the next frame_tick.
- A frame_tick in OPEN has no effect on either bank.
- Hit test for rectangle i: active[i].en && x0≤sx<x1 && y0≤sy<y1. Comparisons are unsigned at COORDWID bits. If x1≤x0 or y1≤y0, the rectangle never hits.
- Priority: the lowest index wins.
- Colour resolution:
  - pix_color = winner colour if hit.
  - pix_color = BG_COLOR if de && !hit.
  - pix_color = 12'h000 if !de; pix_hit is forced to 0 when !de.
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - Both banks have all en=0, coordinates 0 and colour 0.
  - state=OPEN, commit_done=0.
  - All pipeline registers are 0, so pix_de=0, pix_color=0, pix_hit=0, pix_idx=0.
- Reset mid-PEND discards the pending commit. No commit_done is produced.

## Timing
- Pixel pipeline latency is 2 cycles for every signal.
  - Stage 1 registers the per-rectangle hit vector, de, and the active colours needed.
  - Stage 2 registers the priority-encoded winner, colour, pix_hit and pix_idx.
- An active-bank update in cycle T affects the hit tests of pixels sampled in cycle T+1 onward. frame_tick occurs outside the active area, so no visible pixel is torn.
- Write to commit_done, best case:
  - write and commit in cycle C;
  - frame_tick at F>C;
  - copy at the edge ending F;
  - commit_done high in cycle F+1.
- cfg_ready falls in the cycle after a commit is accepted. It rises in the cycle after the copy, which is the same cycle as commit_done.

## Test plan
- Reset: hold rst_pix_n=0 with random sx/sy/de.
  - Expect pix_* = 0 and cfg_ready=1.
  - After release with de=1 and no commits, expect pix_color=12'h142 and pix_hit=0.
- Single rectangle: write idx0 = (en=1, 100, 50, 110, 60, 12'h63F), commit, then frame_tick.
  - Expect commit_done one cycle after the tick.
  - Pixel (100,50) gives 12'h63F and hit=1 two cycles later.
  - (109,59) hits; (110,50) and (100,60) give the background.
- Priority: idx0 = (0,0,20,20, 12'hF00) and idx2 = (10,10,30,30, 12'h0F0).
  - Expect (15,15) → 12'hF00 with idx=0.
  - Expect (25,25) → 12'h0F0 with idx=2.
- Deferred commit: commit, then write attempts before frame_tick.
  - Expect cfg_ready=0 and the shadow unchanged.
  - Old active colours persist until the tick, and new colours appear only after it.
- Same-cycle commit and frame_tick:
  - Expect no copy and no commit_done on that tick.
  - The copy and commit_done happen on the following tick.
- Degenerate cases and reset mid-PEND:
  - A rectangle with x1=x0=40 never hits.
  - de=0 gives color 0 and hit 0 inside a rectangle.
  - Asserting rst_pix_n=0 while in PEND clears it: cfg_ready=1 and no commit_done on the next tick.

Source files
------------

// File: rtl/rect_scheduler_if.sv
// Configuration port of rect_scheduler: descriptor writes, commit request and commit status.
// The client side uses the master modport, the scheduler uses the slave modport.
interface rect_scheduler_if #(
    parameter int unsigned COORDWID = 10,
    parameter int unsigned NRECT    = 4
);
    localparam int unsigned IdxW = $clog2(NRECT);

    logic                cfg_valid;
    logic                cfg_ready;
    logic [IdxW-1:0]     cfg_idx;
    logic                cfg_en;
    logic [COORDWID-1:0] cfg_x0;
    logic [COORDWID-1:0] cfg_y0;
    logic [COORDWID-1:0] cfg_x1;
    logic [COORDWID-1:0] cfg_y1;
    logic [11:0]         cfg_color;
    logic                cfg_commit;
    logic                commit_done;

    modport master (
        output cfg_valid, cfg_idx, cfg_en, cfg_x0, cfg_y0, cfg_x1, cfg_y1, cfg_color, cfg_commit,
        input  cfg_ready, commit_done
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_en, cfg_x0, cfg_y0, cfg_x1, cfg_y1, cfg_color, cfg_commit,
        output cfg_ready, commit_done
    );
endinterface

// File: rtl/rect_scheduler.sv
// Frame-synchronous rectangle layer: shadow/active descriptor banks swapped at frame_tick,
// and a 2-stage per-pixel hit test with lowest-index priority.
module rect_scheduler #(
    parameter int unsigned COORDWID = 10,
    parameter int unsigned NRECT    = 4,
    parameter logic [11:0] BG_COLOR = 12'h142
) (
    input  logic                     pix_clk,
    input  logic                     rst_pix_n,
    input  logic [COORDWID-1:0]      sx,
    input  logic [COORDWID-1:0]      sy,
    input  logic                     de,
    input  logic                     frame_tick,
    rect_scheduler_if.slave          cfg,
    output logic                     pix_de,
    output logic [11:0]              pix_color,
    output logic                     pix_hit,
    output logic [$clog2(NRECT)-1:0] pix_idx
);
    localparam int unsigned IdxW = $clog2(NRECT);

    typedef struct packed {
        logic                en;
        logic [COORDWID-1:0] x0;
        logic [COORDWID-1:0] y0;
        logic [COORDWID-1:0] x1;
        logic [COORDWID-1:0] y1;
        logic [11:0]         color;
    } desc_t;

    typedef enum logic {StOpen, StPend} state_e;

    state_e state_q;
    logic   commit_done_q;
    desc_t  shadow_q [NRECT];
    desc_t  active_q [NRECT];

    logic wr_en;
    assign wr_en           = cfg.cfg_valid && (state_q == StOpen);
    assign cfg.cfg_ready   = (state_q == StOpen);
    assign cfg.commit_done = commit_done_q;

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < NRECT; i++) shadow_q[i] <= '0;
        end else if (wr_en) begin
            shadow_q[cfg.cfg_idx] <= '{en: cfg.cfg_en, x0: cfg.cfg_x0, y0: cfg.cfg_y0,
                                       x1: cfg.cfg_x1, y1: cfg.cfg_y1, color: cfg.cfg_color};
        end
    end

    // A tick arriving with the commit itself is not the boundary for that commit.
    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q       <= StOpen;
            commit_done_q <= 1'b0;
            for (int i = 0; i < NRECT; i++) active_q[i] <= '0;
        end else begin
            commit_done_q <= 1'b0;
            unique case (state_q)
                StOpen: begin
                    if (cfg.cfg_commit) state_q <= StPend;
                end
                StPend: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NRECT; i++) active_q[i] <= shadow_q[i];
                        state_q       <= StOpen;
                        commit_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage 1: per-rectangle hit vector plus the colours stage 2 will choose from.
    logic [NRECT-1:0] hit_d;
    logic [NRECT-1:0] hit1_q;
    logic [11:0]      color1_q [NRECT];
    logic             de1_q;

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NRECT; i++) begin
            hit_d[i] = active_q[i].en &&
                       (sx >= active_q[i].x0) && (sx < active_q[i].x1) &&
                       (sy >= active_q[i].y0) && (sy < active_q[i].y1);
        end
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hit1_q <= '0;
            de1_q  <= 1'b0;
            for (int i = 0; i < NRECT; i++) color1_q[i] <= '0;
        end else begin
            hit1_q <= hit_d;
            de1_q  <= de;
            for (int i = 0; i < NRECT; i++) color1_q[i] <= active_q[i].color;
        end
    end

    // Stage 2: scan from the top so the lowest set index is the one left standing.
    logic            win_hit;
    logic [IdxW-1:0] win_idx;
    logic [11:0]     win_color;

    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        win_color = '0;
        for (int i = NRECT - 1; i >= 0; i--) begin
            if (hit1_q[i]) begin
                win_hit   = 1'b1;
                win_idx   = IdxW'(i);
                win_color = color1_q[i];
            end
        end
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            pix_de    <= 1'b0;
            pix_hit   <= 1'b0;
            pix_idx   <= '0;
            pix_color <= '0;
        end else begin
            pix_de    <= de1_q;
            pix_hit   <= de1_q && win_hit;
            pix_idx   <= (de1_q && win_hit) ? win_idx : '0;
            pix_color <= !de1_q ? 12'h000 : (win_hit ? win_color : BG_COLOR);
        end
    end
endmodule

// File: tb/tb_rect_scheduler.sv
// Directed bench for rect_scheduler: commit timing, priority, deferred and same-cycle commits,
// degenerate rectangles, de gating and reset while a commit is pending.
module tb_rect_scheduler;
    logic       pix_clk = 1'b0;
    logic       rst_pix_n;
    logic [9:0] sx, sy;
    logic       de, frame_tick;
    logic       pix_de, pix_hit;
    logic [11:0] pix_color;
    logic [1:0] pix_idx;

    int n_checks = 0;
    int n_pass   = 0;

    rect_scheduler_if #(.COORDWID(10), .NRECT(4)) cfg_if ();

    rect_scheduler #(.COORDWID(10), .NRECT(4), .BG_COLOR(12'h142)) dut (
        .pix_clk    (pix_clk),
        .rst_pix_n  (rst_pix_n),
        .sx         (sx),
        .sy         (sy),
        .de         (de),
        .frame_tick (frame_tick),
        .cfg        (cfg_if),
        .pix_de     (pix_de),
        .pix_color  (pix_color),
        .pix_hit    (pix_hit),
        .pix_idx    (pix_idx)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic d);
        sx = x; sy = y; de = d;
        tick();
        tick();
    endtask

    task automatic write_desc(input logic [1:0] idx, input logic en, input logic [9:0] x0,
                              input logic [9:0] y0, input logic [9:0] x1, input logic [9:0] y1,
                              input logic [11:0] color, input logic commit, input logic ft);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_idx = idx; cfg_if.cfg_en = en;
        cfg_if.cfg_x0 = x0; cfg_if.cfg_y0 = y0; cfg_if.cfg_x1 = x1; cfg_if.cfg_y1 = y1;
        cfg_if.cfg_color = color; cfg_if.cfg_commit = commit; frame_tick = ft;
        tick();
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_commit = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic commit_only();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
    endtask

    task automatic do_frame_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_pix_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sx = 10'($urandom); sy = 10'($urandom); de = 1'($urandom);
            tick();
        end
        n_checks++;
        if ({pix_de, pix_hit, pix_idx, pix_color} !== 16'h0)
            $display("FAIL reset_pix: got %h want 0000", {pix_de, pix_hit, pix_idx, pix_color});
        else n_pass++;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready);
        else n_pass++;
        rst_pix_n = 1'b1;
        drive_pix(10'd5, 10'd5, 1'b1);
        n_checks++;
        if ({pix_de, pix_hit, pix_idx, pix_color} !== {1'b1, 1'b0, 2'd0, 12'h142})
            $display("FAIL reset_bg: got %h want %h", {pix_de, pix_hit, pix_idx, pix_color},
                     {1'b1, 1'b0, 2'd0, 12'h142});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [15:0] exp_v [4];
        logic [9:0]  px [4];
        logic [9:0]  py [4];
        write_desc(2'd0, 1'b1, 10'd100, 10'd50, 10'd110, 10'd60, 12'h63F, 1'b0, 1'b0);
        commit_only();
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) $display("FAIL single_ready_low: got %b want 0", cfg_if.cfg_ready);
        else n_pass++;
        do_frame_tick();
        n_checks++;
        if (cfg_if.commit_done !== 1'b1) $display("FAIL single_done: got %b want 1", cfg_if.commit_done);
        else n_pass++;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) $display("FAIL single_ready_high: got %b want 1", cfg_if.cfg_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (cfg_if.commit_done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", cfg_if.commit_done);
        else n_pass++;
        px = '{10'd100, 10'd109, 10'd110, 10'd100};
        py = '{10'd50, 10'd59, 10'd50, 10'd60};
        exp_v = '{{1'b1, 1'b1, 2'd0, 12'h63F}, {1'b1, 1'b1, 2'd0, 12'h63F},
                  {1'b1, 1'b0, 2'd0, 12'h142}, {1'b1, 1'b0, 2'd0, 12'h142}};
        for (int i = 0; i < 4; i++) begin
            drive_pix(px[i], py[i], 1'b1);
            n_checks++;
            if ({pix_de, pix_hit, pix_idx, pix_color} !== exp_v[i])
                $display("FAIL single_pix(%0d,%0d): got %h want %h", px[i], py[i],
                         {pix_de, pix_hit, pix_idx, pix_color}, exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        write_desc(2'd0, 1'b1, 10'd0, 10'd0, 10'd20, 10'd20, 12'hF00, 1'b0, 1'b0);
        write_desc(2'd2, 1'b1, 10'd10, 10'd10, 10'd30, 10'd30, 12'h0F0, 1'b1, 1'b0);
        do_frame_tick();
        drive_pix(10'd15, 10'd15, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b1, 2'd0, 12'hF00})
            $display("FAIL prio_overlap: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b1, 2'd0, 12'hF00});
        else n_pass++;
        drive_pix(10'd25, 10'd25, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b1, 2'd2, 12'h0F0})
            $display("FAIL prio_idx2: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b1, 2'd2, 12'h0F0});
        else n_pass++;
    endtask

    task automatic test_deferred();
        // Write and commit together: the write belongs to this commit.
        write_desc(2'd1, 1'b1, 10'd200, 10'd200, 10'd210, 10'd210, 12'h00F, 1'b1, 1'b0);
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) $display("FAIL defer_ready: got %b want 0", cfg_if.cfg_ready);
        else n_pass++;
        write_desc(2'd1, 1'b1, 10'd200, 10'd200, 10'd210, 10'd210, 12'hABC, 1'b1, 1'b0);
        drive_pix(10'd205, 10'd205, 1'b1);
        n_checks++;
        if ({pix_hit, pix_color} !== {1'b0, 12'h142})
            $display("FAIL defer_old_active: got %h want %h", {pix_hit, pix_color}, {1'b0, 12'h142});
        else n_pass++;
        do_frame_tick();
        n_checks++;
        if (cfg_if.commit_done !== 1'b1) $display("FAIL defer_done: got %b want 1", cfg_if.commit_done);
        else n_pass++;
        drive_pix(10'd205, 10'd205, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b1, 2'd1, 12'h00F})
            $display("FAIL defer_new_active: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b1, 2'd1, 12'h00F});
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        write_desc(2'd3, 1'b1, 10'd300, 10'd300, 10'd310, 10'd310, 12'h777, 1'b1, 1'b1);
        n_checks++;
        if ({cfg_if.commit_done, cfg_if.cfg_ready} !== 2'b00)
            $display("FAIL same_no_copy: got %b want 00", {cfg_if.commit_done, cfg_if.cfg_ready});
        else n_pass++;
        drive_pix(10'd305, 10'd305, 1'b1);
        n_checks++;
        if ({pix_hit, pix_color} !== {1'b0, 12'h142})
            $display("FAIL same_still_old: got %h want %h", {pix_hit, pix_color}, {1'b0, 12'h142});
        else n_pass++;
        do_frame_tick();
        n_checks++;
        if (cfg_if.commit_done !== 1'b1) $display("FAIL same_done_next: got %b want 1", cfg_if.commit_done);
        else n_pass++;
        drive_pix(10'd305, 10'd305, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b1, 2'd3, 12'h777})
            $display("FAIL same_new: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b1, 2'd3, 12'h777});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9:0]  px [4];
        logic [15:0] exp_v [4];
        px = '{10'd15, 10'd25, 10'd305, 10'd205};
        exp_v = '{{1'b1, 1'b1, 2'd0, 12'hF00}, {1'b1, 1'b1, 2'd2, 12'h0F0},
                  {1'b1, 1'b1, 2'd3, 12'h777}, {1'b1, 1'b1, 2'd1, 12'h00F}};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin sx = px[k]; sy = px[k]; de = 1'b1; end
            else de = 1'b0;
            tick();
            if (k >= 1) begin
                n_checks++;
                if ({pix_de, pix_hit, pix_idx, pix_color} !== exp_v[k-1])
                    $display("FAIL b2b_%0d: got %h want %h", k - 1,
                             {pix_de, pix_hit, pix_idx, pix_color}, exp_v[k-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_degenerate();
        write_desc(2'd1, 1'b1, 10'd40, 10'd0, 10'd40, 10'd100, 12'hABC, 1'b1, 1'b0);
        do_frame_tick();
        drive_pix(10'd40, 10'd50, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b0, 2'd0, 12'h142})
            $display("FAIL degen_zero_width: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b0, 2'd0, 12'h142});
        else n_pass++;
        drive_pix(10'd15, 10'd15, 1'b0);
        n_checks++;
        if ({pix_de, pix_hit, pix_idx, pix_color} !== 16'h0)
            $display("FAIL degen_de_low: got %h want 0000", {pix_de, pix_hit, pix_idx, pix_color});
        else n_pass++;
    endtask

    task automatic test_reset_mid_pend();
        write_desc(2'd2, 1'b1, 10'd0, 10'd0, 10'd50, 10'd50, 12'h555, 1'b1, 1'b0);
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) $display("FAIL rstpend_in_pend: got %b want 1'b0", cfg_if.cfg_ready);
        else n_pass++;
        rst_pix_n = 1'b0;
        #2;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) $display("FAIL rstpend_ready: got %b want 1", cfg_if.cfg_ready);
        else n_pass++;
        tick();
        rst_pix_n = 1'b1;
        tick();
        do_frame_tick();
        n_checks++;
        if (cfg_if.commit_done !== 1'b0) $display("FAIL rstpend_no_done: got %b want 0", cfg_if.commit_done);
        else n_pass++;
        drive_pix(10'd15, 10'd15, 1'b1);
        n_checks++;
        if ({pix_hit, pix_idx, pix_color} !== {1'b0, 2'd0, 12'h142})
            $display("FAIL rstpend_cleared: got %h want %h", {pix_hit, pix_idx, pix_color},
                     {1'b0, 2'd0, 12'h142});
        else n_pass++;
    endtask

    initial begin
        rst_pix_n = 1'b0;
        sx = '0; sy = '0; de = 1'b0; frame_tick = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_idx = '0; cfg_if.cfg_en = 1'b0;
        cfg_if.cfg_x0 = '0; cfg_if.cfg_y0 = '0; cfg_if.cfg_x1 = '0; cfg_if.cfg_y1 = '0;
        cfg_if.cfg_color = '0; cfg_if.cfg_commit = 1'b0;
        #1;
        test_reset();
        test_single();
        test_priority();
        test_deferred();
        test_same_cycle();
        test_back_to_back();
        test_degenerate();
        test_reset_mid_pend();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
